// File: rtl/wb_writeback_stage_pkg.sv
// rtl/wb_writeback_stage_pkg.sv - shared constants and state type for the writeback stage
`timescale 1ns/1ps
package wb_writeback_stage_pkg;

    // Writeback source select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        LOAD_WAIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_writeback_stage_if.sv
// rtl/wb_writeback_stage_if.sv - MEM-to-WB retire handshake bundle
// master: MEM stage (drives instruction fields, m_valid); slave: writeback stage (drives m_ready)
`timescale 1ns/1ps
interface wb_writeback_stage_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
);
    logic               m_valid;
    logic               m_ready;
    logic               m_reg_write;
    logic [RADDR_W-1:0] m_rd;
    logic [1:0]         m_wb_sel;
    logic [XLEN-1:0]    m_alu_result;
    logic [XLEN-1:0]    m_pc_plus4;
    logic [2:0]         m_funct3;

    modport master (
        output m_valid, m_reg_write, m_rd, m_wb_sel, m_alu_result, m_pc_plus4, m_funct3,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_reg_write, m_rd, m_wb_sel, m_alu_result, m_pc_plus4, m_funct3,
        output m_ready
    );
endinterface

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - load data extraction and extension with alignment check
// in: funct3 (load type), off (byte offset), rdata (aligned word); out: data (extended), err (misaligned/illegal)
`timescale 1ns/1ps
module wb_load_align
    import wb_writeback_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            err
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // off[0] is ignored here; a halfword with off[0]=1 is flagged below
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data = {{(XLEN-16){half_sel[15]}}, half_sel};
                err  = off[0];
            end
            F3_LHU: begin
                data = {{(XLEN-16){1'b0}}, half_sel};
                err  = off[0];
            end
            F3_LW: begin
                data = rdata;
                err  = (off != 2'd0);
            end
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/wb_writeback_stage.sv
// rtl/wb_writeback_stage.sv - MEM/WB register, load wait and register-file writeback
// ports: clk, rst_n (async active-low); m (retire handshake, slave); dmem_rvalid/dmem_rdata (load response);
//        rf_write/rf_waddr/rf_wdata (register-file write); load_pending/load_pending_rd/load_err (hazard unit)
`timescale 1ns/1ps
module wb_writeback_stage
    import wb_writeback_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    wb_writeback_stage_if.slave m,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                rf_write,
    output logic [RADDR_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic                load_pending,
    output logic [RADDR_W-1:0]  load_pending_rd,
    output logic                load_err
);
    wb_state_e          state_q, state_d;
    logic [RADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic [2:0]         ld_f3_q, ld_f3_d;
    logic [1:0]         ld_off_q, ld_off_d;
    logic               ld_rw_q, ld_rw_d;

    logic               rf_write_d, load_pending_d, load_err_d;
    logic [RADDR_W-1:0] rf_waddr_d, pend_rd_d;
    logic [XLEN-1:0]    rf_wdata_d;

    logic [XLEN-1:0]    al_data;
    logic               al_err;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .funct3 (ld_f3_q),
        .off    (ld_off_q),
        .rdata  (dmem_rdata),
        .data   (al_data),
        .err    (al_err)
    );

    assign m.m_ready = (state_q != LOAD_WAIT);

    always_comb begin
        state_d        = state_q;
        ld_rd_d        = ld_rd_q;
        ld_f3_d        = ld_f3_q;
        ld_off_d       = ld_off_q;
        ld_rw_d        = ld_rw_q;
        rf_write_d     = 1'b0;
        rf_waddr_d     = rf_waddr;
        rf_wdata_d     = rf_wdata;
        load_pending_d = load_pending;
        pend_rd_d      = load_pending_rd;
        load_err_d     = 1'b0;

        case (state_q)
            IDLE, WRITE: begin
                state_d = IDLE;
                if (m.m_valid) begin
                    if (m.m_wb_sel == WB_SEL_LOAD) begin
                        state_d        = LOAD_WAIT;
                        ld_rd_d        = m.m_rd;
                        ld_f3_d        = m.m_funct3;
                        ld_off_d       = m.m_alu_result[1:0];
                        ld_rw_d        = m.m_reg_write;
                        load_pending_d = 1'b1;
                        pend_rd_d      = m.m_rd;
                    end else begin
                        // select 11 is reserved and behaves like the ALU path
                        state_d    = WRITE;
                        rf_write_d = m.m_reg_write && (m.m_rd != '0);
                        rf_waddr_d = m.m_rd;
                        rf_wdata_d = (m.m_wb_sel == WB_SEL_PC4) ? m.m_pc_plus4 : m.m_alu_result;
                    end
                end
            end
            LOAD_WAIT: begin
                if (dmem_rvalid) begin
                    state_d        = WRITE;
                    rf_write_d     = ld_rw_q && (ld_rd_q != '0) && !al_err;
                    rf_waddr_d     = ld_rd_q;
                    rf_wdata_d     = al_data;
                    load_err_d     = al_err;
                    load_pending_d = 1'b0;
                    pend_rd_d      = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ld_rd_q         <= '0;
            ld_f3_q         <= '0;
            ld_off_q        <= '0;
            ld_rw_q         <= 1'b0;
            rf_write        <= 1'b0;
            rf_waddr        <= '0;
            rf_wdata        <= '0;
            load_pending    <= 1'b0;
            load_pending_rd <= '0;
            load_err        <= 1'b0;
        end else begin
            state_q         <= state_d;
            ld_rd_q         <= ld_rd_d;
            ld_f3_q         <= ld_f3_d;
            ld_off_q        <= ld_off_d;
            ld_rw_q         <= ld_rw_d;
            rf_write        <= rf_write_d;
            rf_waddr        <= rf_waddr_d;
            rf_wdata        <= rf_wdata_d;
            load_pending    <= load_pending_d;
            load_pending_rd <= pend_rd_d;
            load_err        <= load_err_d;
        end
    end
endmodule

// File: doc/wb_writeback_stage.md
Name: wb_writeback_stage

Overview:
MEM/WB pipeline register plus writeback logic for the RV32I 5-stage core. It is the write-side master of the register-file write port and drives `write`, `waddr` and `wdata`.
- Accepts retiring instructions from MEM through a valid/ready handshake.
- Waits for variable-latency data-memory load responses.
- Extracts and sign- or zero-extends load data.
- Exposes the in-flight writeback to the hazard/forwarding unit.

Parameters:
XLEN, 32, datapath width
RADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
m_valid  in  1  MEM stage presents an instruction
m_ready  out  1  stage can accept this cycle
m_reg_write  in  1  instruction writes rd
m_rd  in  RADDR_W  destination register
m_wb_sel  in  2  00 ALU result, 01 load data, 10 PC+4, 11 reserved (treated as 00)
m_alu_result  in  XLEN  ALU result / effective address
m_pc_plus4  in  XLEN  link value
m_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
dmem_rvalid  in  1  load data valid
dmem_rdata  in  XLEN  aligned 32-bit word from data memory
rf_write  out  1  register-file write enable
rf_waddr  out  RADDR_W  register-file write address
rf_wdata  out  XLEN  register-file write data
load_pending  out  1  a load is awaiting dmem_rvalid
load_pending_rd  out  RADDR_W  rd of the pending load (0 when none)
load_err  out  1  one-cycle pulse: misaligned or illegal load

Behaviour:
- Reset (async, rst_n=0): state IDLE; rf_write=0, rf_waddr=0, rf_wdata=0, load_pending=0, load_pending_rd=0, load_err=0. m_ready=1 once reset is released. Any in-flight load is dropped; a late dmem_rvalid after reset is ignored.
- States:
  - IDLE: no output pending.
  - WRITE: outputs valid for exactly one cycle.
  - LOAD_WAIT: waiting for load data.
- m_ready = (state != LOAD_WAIT). Accept = m_valid & m_ready. Accepting in WRITE is legal, giving back-to-back writes every cycle.
- Non-load accept in cycle N (wb_sel != 01): in cycle N+1 the stage is in WRITE with:
  - rf_write = m_reg_write & (m_rd != 0)
  - rf_waddr = m_rd
  - rf_wdata = selected source
- Load accept in cycle N (wb_sel = 01): go to LOAD_WAIT. Latch rd, funct3, byte offset = m_alu_result[1:0], and reg_write. load_pending=1 and load_pending_rd=rd from cycle N+1.
- dmem_rvalid is sampled only in LOAD_WAIT. On dmem_rvalid in cycle M, the stage is in WRITE in cycle M+1 and load_pending drops in M+1.
- Load extraction (off = byte offset):
  - LB/LBU: byte rdata[8*off+7 : 8*off]
  - LH/LHU: half rdata[16*off[1]+15 : 16*off[1]]
  - LW: full word
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Misalignment: LH/LHU with off[0]=1, or LW with off!=0.
- Error case (misaligned, or funct3 in {011, 110, 111}): rf_write=0 in the WRITE cycle and load_err=1 for that cycle. The stage still returns to normal operation.
- rd=0: never asserts rf_write, for any source.
- No new accept in cycle M+1 → WRITE goes to IDLE in cycle M+2 and rf_write drops. rf_waddr and rf_wdata hold their last values.
- dmem_rvalid outside LOAD_WAIT is ignored and has no side effects.
- m_valid while in LOAD_WAIT is not accepted; MEM must hold it.
- All outputs are registered. Latency is 1 cycle for ALU/PC+4 results, and dmem latency + 1 for loads.

Decomposition:
- Shared package holds:
  - WB_SEL_ALU/LOAD/PC4 constants
  - funct3 load constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
  - state enum: IDLE, WRITE, LOAD_WAIT
- One combinational sub-module, wb_load_align: inputs funct3, off, rdata; outputs data, err.
- The FSM and registers stay in wb_writeback_stage.

Test Plan:
- Reset/idle: assert rst_n=0 mid-LOAD_WAIT (rd=5) → all outputs 0 immediately, m_ready=1 after release. A following dmem_rvalid causes no write.
- ALU back-to-back: accept ADD (rd=3, alu=0x0000_0010) then JAL (rd=1, pc+4=0x0000_0104, wb_sel=10) on consecutive cycles. Required rf_write=1 on both subsequent cycles:
  - first: rf_waddr=3, rf_wdata=0x10
  - second: rf_waddr=1, rf_wdata=0x104
- Load, 3-cycle dmem latency: LB rd=7, addr off=2, rdata=0x12_80_34_56. Required:
  - m_ready=0 and load_pending_rd=7 for 3 cycles
  - then rf_write=1, rf_waddr=7, rf_wdata=0xFFFF_FF80
  - repeat with LBU → rf_wdata=0x0000_0080
- Halfword/word: rdata=0x8001_7FFE:
  - LH off=2 → 0xFFFF_8001
  - LHU off=0 → 0x0000_7FFE
  - LW off=0 → 0x8001_7FFE
- Errors: LW off=2 or funct3=011 → rf_write=0 and load_err pulses exactly 1 cycle; the next ALU instruction writes normally.
- x0 and spurious response: ALU with rd=0, reg_write=1 → rf_write=0. dmem_rvalid pulsed in IDLE → no state change and no write.
